// File: rtl/jtframe_vidgen.sv
// Programmable raster timing generator: pixel/line counters plus registered
// blanking and sync decodes, all advancing on the shared pixel clock enable.
module jtframe_vidgen #(
    parameter logic [9:0] HCNT_START = 10'd0,
    parameter logic [9:0] HCNT_END   = 10'd383,
    parameter logic [9:0] HB_START   = 10'd256,
    parameter logic [9:0] HB_END     = 10'd0,
    parameter logic [9:0] HS_START   = 10'd296,
    parameter logic [9:0] HS_END     = 10'd328,
    parameter logic [9:0] VCNT_START = 10'd0,
    parameter logic [9:0] VCNT_END   = 10'd263,
    parameter logic [9:0] VB_START   = 10'd240,
    parameter logic [9:0] VB_END     = 10'd16,
    parameter logic [9:0] VS_START   = 10'd248,
    parameter logic [9:0] VS_END     = 10'd252
) (
    input  logic       rst,
    input  logic       clk,
    input  logic       pxl_cen,
    output logic [8:0] hdump,
    output logic [8:0] vdump,
    output logic [8:0] vrender,
    output logic       lhbl,
    output logic       lvbl,
    output logic       hs,
    output logic       vs,
    output logic [7:0] frame
);

    localparam logic [8:0] H0  = HCNT_START[8:0];
    localparam logic [8:0] H1  = HCNT_END[8:0];
    localparam logic [8:0] V0  = VCNT_START[8:0];
    localparam logic [8:0] V1  = VCNT_END[8:0];
    localparam logic [8:0] VR0 = (VCNT_START == VCNT_END) ? V0 : V0 + 9'd1;

    logic       hwrap;
    logic       vwrap;
    logic [8:0] hnext;
    logic [8:0] vnext;
    logic [8:0] vrnext;
    logic [9:0] hext;
    logic [9:0] vext;
    logic [9:0] vcur;

    // Next counter values; the decodes below look at these so that they
    // line up with hdump/vdump instead of lagging by one pixel.
    always_comb begin
        hwrap  = (hdump == H1);
        hnext  = hwrap ? H0 : hdump + 9'd1;
        vwrap  = (vdump == V1);
        vnext  = vwrap ? V0 : vrender;
        vrnext = vwrap ? VR0 : ((vrender == V1) ? V0 : vrender + 9'd1);
        hext   = {1'b0, hnext};
        vext   = {1'b0, vnext};
        vcur   = {1'b0, vdump};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hdump   <= H0;
            vdump   <= V0;
            vrender <= VR0;
            lhbl    <= 1'b0;
            lvbl    <= 1'b0;
            hs      <= 1'b0;
            vs      <= 1'b0;
            frame   <= 8'd0;
        end else if (pxl_cen) begin
            hdump <= hnext;
            lhbl  <= (hext >= HB_END) && (hext < HB_START);
            hs    <= (hext >= HS_START) && (hext < HS_END);
            if (hwrap) begin
                vdump   <= vnext;
                vrender <= vrnext;
                lvbl    <= (vext >= VB_END) && (vext < VB_START);
                if (vwrap)
                    frame <= frame + 8'd1;
            end
            // vs only changes together with an hs rising edge
            if (hext == HS_START)
                vs <= (vcur >= VS_START) && (vcur < VS_END);
        end
    end

endmodule

// File: tb/tb_jtframe_vidgen.sv
// Scoreboard bench for jtframe_vidgen: four instances with different
// geometries, expected states queued by the stimulus and popped by a monitor.
module tb_jtframe_vidgen;

    typedef struct {
        int hs0, he, hbe, hbs, hss, hse, vs0, ve, vbe, vbs, vss, vse;
    } prm_t;

    typedef struct {
        int h, v, vr;
        bit lhbl, lvbl, hs, vs;
        int frame;
    } st_t;

    typedef struct {
        int         d;
        logic [38:0] exp;
    } item_t;

    logic       clk = 1'b0;
    logic [3:0] cen = '0;
    logic [3:0] rst = '0;
    logic [8:0] hd [4];
    logic [8:0] vd [4];
    logic [8:0] vr [4];
    logic       lh [4];
    logic       lv [4];
    logic       hsy [4];
    logic       vsy [4];
    logic [7:0] fr [4];

    int checks = 0;
    int errors = 0;

    prm_t  pr [4];
    st_t   st [4];
    item_t sbq [$];
    item_t it;
    logic [38:0] last [4];
    bit    last_ok [4];

    always #5 clk = ~clk;

    jtframe_vidgen u0 (
        .rst(rst[0]), .clk(clk), .pxl_cen(cen[0]),
        .hdump(hd[0]), .vdump(vd[0]), .vrender(vr[0]),
        .lhbl(lh[0]), .lvbl(lv[0]), .hs(hsy[0]), .vs(vsy[0]), .frame(fr[0])
    );

    jtframe_vidgen #(
        .HCNT_START(10'd64), .HCNT_END(10'd447), .HB_END(10'd80), .HB_START(10'd400)
    ) u1 (
        .rst(rst[1]), .clk(clk), .pxl_cen(cen[1]),
        .hdump(hd[1]), .vdump(vd[1]), .vrender(vr[1]),
        .lhbl(lh[1]), .lvbl(lv[1]), .hs(hsy[1]), .vs(vsy[1]), .frame(fr[1])
    );

    jtframe_vidgen #(
        .HCNT_END(10'd15), .HB_START(10'd10), .HB_END(10'd0),
        .HS_START(10'd12), .HS_END(10'd14)
    ) u2 (
        .rst(rst[2]), .clk(clk), .pxl_cen(cen[2]),
        .hdump(hd[2]), .vdump(vd[2]), .vrender(vr[2]),
        .lhbl(lh[2]), .lvbl(lv[2]), .hs(hsy[2]), .vs(vsy[2]), .frame(fr[2])
    );

    jtframe_vidgen #(
        .HCNT_END(10'd3), .HB_START(10'd2), .HB_END(10'd0), .HS_START(10'd2), .HS_END(10'd3),
        .VCNT_END(10'd3), .VB_END(10'd1), .VB_START(10'd3), .VS_START(10'd2), .VS_END(10'd3)
    ) u3 (
        .rst(rst[3]), .clk(clk), .pxl_cen(cen[3]),
        .hdump(hd[3]), .vdump(vd[3]), .vrender(vr[3]),
        .lhbl(lh[3]), .lvbl(lv[3]), .hs(hsy[3]), .vs(vsy[3]), .frame(fr[3])
    );

    function automatic st_t model_reset(prm_t p);
        st_t s;
        s.h = p.hs0;
        s.v = p.vs0;
        s.vr = (p.vs0 == p.ve) ? p.vs0 : p.vs0 + 1;
        s.lhbl = 0; s.lvbl = 0; s.hs = 0; s.vs = 0;
        s.frame = 0;
        return s;
    endfunction

    function automatic st_t model_step(prm_t p, st_t s);
        st_t n;
        int  hn;
        n = s;
        hn = (s.h == p.he) ? p.hs0 : s.h + 1;
        n.h = hn;
        n.lhbl = (hn >= p.hbe) && (hn < p.hbs);
        n.hs = (hn >= p.hss) && (hn < p.hse);
        if (s.h == p.he) begin
            if (s.v == p.ve) begin
                n.v = p.vs0;
                n.vr = (p.vs0 == p.ve) ? p.vs0 : p.vs0 + 1;
                n.frame = (s.frame + 1) % 256;
            end else begin
                n.v = s.vr;
                n.vr = (s.vr == p.ve) ? p.vs0 : s.vr + 1;
            end
            n.lvbl = (n.v >= p.vbe) && (n.v < p.vbs);
        end
        if (hn == p.hss)
            n.vs = (s.v >= p.vss) && (s.v < p.vse);
        return n;
    endfunction

    function automatic logic [38:0] pack_st(st_t s);
        return {9'(s.h), 9'(s.v), 9'(s.vr), s.lhbl, s.lvbl, s.hs, s.vs, 8'(s.frame)};
    endfunction

    function automatic logic [38:0] obs(int d);
        return {hd[d], vd[d], vr[d], lh[d], lv[d], hsy[d], vsy[d], fr[d]};
    endfunction

    task automatic checkOutput(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every reset or pxl_cen edge pops one expected state; any other
    // edge must leave the outputs untouched.
    always @(posedge clk) begin
        logic [3:0] ev;
        ev = cen | rst;
        #1;
        for (int d = 0; d < 4; d++) begin
            if (ev[d]) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL scoreboard empty: dut %0d produced %h", d, obs(d));
                end else begin
                    it = sbq.pop_front();
                    if (it.d != d || obs(d) !== it.exp) begin
                        errors++;
                        $display("[TB] FAIL dut%0d state: got %h, expected %h (entry for dut%0d)",
                                 d, obs(d), it.exp, it.d);
                    end
                end
                last_ok[d] = 1;
            end else if (last_ok[d]) begin
                checks++;
                if (obs(d) !== last[d]) begin
                    errors++;
                    $display("[TB] FAIL dut%0d hold: got %h, expected %h", d, obs(d), last[d]);
                end
            end
            last[d] = obs(d);
        end
    end

    task automatic applyStimulus(int d, int gap);
        @(negedge clk);
        cen[d] = 1'b1;
        st[d] = model_step(pr[d], st[d]);
        sbq.push_back('{d, pack_st(st[d])});
        @(posedge clk);
        #2;
        if (gap > 0) begin
            @(negedge clk);
            cen[d] = 1'b0;
            repeat (gap - 1) @(negedge clk);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        cen = '0;
    endtask

    task automatic doReset(logic [3:0] mask);
        @(negedge clk);
        rst = mask;
        for (int d = 0; d < 4; d++) begin
            if (mask[d]) begin
                st[d] = model_reset(pr[d]);
                sbq.push_back('{d, pack_st(st[d])});
            end
        end
        @(negedge clk);
        rst = '0;
    endtask

    initial begin
        int nl, nh, nv, nvs, vmax, rise_h, rise_v, fall_h, fall_v;
        bit prev_vs;
        pr[0] = '{0, 383, 0, 256, 296, 328, 0, 263, 16, 240, 248, 252};
        pr[1] = '{64, 447, 80, 400, 296, 328, 0, 263, 16, 240, 248, 252};
        pr[2] = '{0, 15, 0, 10, 12, 14, 0, 263, 16, 240, 248, 252};
        pr[3] = '{0, 3, 0, 2, 2, 3, 0, 3, 1, 3, 2, 3};
        for (int d = 0; d < 4; d++) last_ok[d] = 0;

        doReset(4'hF);
        checkOutput("reset vrender", int'(vr[0]), 1);

        // one full default line
        nl = 0; nh = 0;
        for (int i = 1; i <= 384; i++) begin
            applyStimulus(0, 0);
            if (lh[0]) nl++;
            if (hsy[0]) nh++;
            if (i == 383) checkOutput("t1 hdump last", int'(hd[0]), 383);
        end
        idle();
        checkOutput("t1 lhbl pulses", nl, 256);
        checkOutput("t1 hs pulses", nh, 32);
        checkOutput("t1 hdump wrap", int'(hd[0]), 0);
        checkOutput("t1 vdump", int'(vd[0]), 1);
        checkOutput("t1 vrender", int'(vr[0]), 2);

        // same line with pxl_cen 1-in-4
        nh = 0;
        for (int i = 1; i <= 384; i++) begin
            applyStimulus(0, 3);
            if (hsy[0]) nh++;
        end
        checkOutput("t4 hs pulses", nh, 32);
        checkOutput("t4 vdump", int'(vd[0]), 2);

        // mid-frame reset with pxl_cen low
        for (int i = 0; i < 48 * 384 + 100; i++) applyStimulus(0, 0);
        idle();
        checkOutput("t5 hdump before", int'(hd[0]), 100);
        checkOutput("t5 vdump before", int'(vd[0]), 50);
        doReset(4'b0001);
        checkOutput("t5 hdump", int'(hd[0]), 0);
        checkOutput("t5 vrender", int'(vr[0]), 1);
        checkOutput("t5 hs", int'(hsy[0]), 0);
        applyStimulus(0, 0);
        idle();
        checkOutput("t5 lhbl first", int'(lh[0]), 1);

        // full frame with short lines and default vertical timing
        nv = 0; nvs = 0; vmax = 0; prev_vs = 0;
        rise_h = -1; rise_v = -1; fall_h = -1; fall_v = -1;
        for (int i = 1; i <= 264 * 16; i++) begin
            applyStimulus(2, 0);
            if (lv[2]) nv++;
            if (vsy[2]) nvs++;
            if (int'(vd[2]) > vmax) vmax = int'(vd[2]);
            if (vsy[2] && !prev_vs) begin rise_h = int'(hd[2]); rise_v = int'(vd[2]); end
            if (!vsy[2] && prev_vs) begin fall_h = int'(hd[2]); fall_v = int'(vd[2]); end
            prev_vs = vsy[2];
            checkOutput("t2 vrender", int'(vr[2]), (int'(vd[2]) + 1) % 264);
        end
        idle();
        checkOutput("t2 lvbl pulses", nv, 224 * 16);
        checkOutput("t3 vs pulses", nvs, 4 * 16);
        checkOutput("t3 vs rise h", rise_h, 12);
        checkOutput("t3 vs rise v", rise_v, 248);
        checkOutput("t3 vs fall h", fall_h, 12);
        checkOutput("t3 vs fall v", fall_v, 252);
        checkOutput("t2 vdump max", vmax, 263);
        checkOutput("t2 vdump wrap", int'(vd[2]), 0);
        checkOutput("t2 frame", int'(fr[2]), 1);

        // non-default horizontal geometry
        nl = 0;
        for (int i = 1; i <= 384; i++) begin
            applyStimulus(1, 0);
            if (lh[1]) nl++;
            if (i == 383) checkOutput("t6 hdump last", int'(hd[1]), 447);
        end
        idle();
        checkOutput("t6 hdump wrap", int'(hd[1]), 64);
        checkOutput("t6 lhbl pulses", nl, 320);
        checkOutput("t6 vdump", int'(vd[1]), 1);

        // frame counter wrap on a 4x4 raster
        for (int i = 1; i <= 256 * 16; i++) begin
            applyStimulus(3, 0);
            if (i == 255 * 16) checkOutput("t7 frame 255", int'(fr[3]), 255);
        end
        idle();
        checkOutput("t7 frame wrap", int'(fr[3]), 0);

        repeat (4) @(negedge clk);
        checkOutput("scoreboard drained", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
